mac_accumulator: RTL and testbench

Downstream stage of the multiplier core. Consumes its registered product stream (valid-only, no backpressure) and sums a programmed number of consecutive products into a dot-product result. The sum saturates at ACC_WIDTH. Completed results are queued in a 2-entry output FIFO with a valid/ready handshake, so a stalled consumer never stalls the multiplier. Results lost because the FIFO is full are flagged, never silently corrupted.

---
 rtl/mac_accumulator_if.sv | 33 +++
 rtl/mac_accumulator.sv | 126 ++++++++++++
 tb/tb_mac_accumulator.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_accumulator_if
// Description : Product-in / result-out bundle for the dot-product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_accumulator_if #(
    parameter int IN_DATA_WIDTH = 16,
    parameter int ACC_WIDTH     = 24,
    parameter int LEN_WIDTH     = 8
);
    logic                     i_start;
    logic [LEN_WIDTH-1:0]     i_len;
    logic                     i_valid;
    logic [IN_DATA_WIDTH-1:0] i_product;
    logic                     o_valid;
    logic [ACC_WIDTH-1:0]     o_result;
    logic                     o_sat;
    logic                     i_ready;
    logic                     o_busy;
    logic                     o_overrun;

    modport master (
        output i_start, i_len, i_valid, i_product, i_ready,
        input  o_valid, o_result, o_sat, o_busy, o_overrun
    );

    modport slave (
        input  i_start, i_len, i_valid, i_product, i_ready,
        output o_valid, o_result, o_sat, o_busy, o_overrun
    );
endinterface
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mac_accumulator
// Description : Saturating dot-product accumulator with a 2-entry result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
    parameter int IN_DATA_WIDTH = 16,
    parameter int ACC_WIDTH     = 24,
    parameter int LEN_WIDTH     = 8
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    mac_accumulator_if.slave  bus
);
    localparam logic [0:0]           c_idle    = 1'b0;
    localparam logic [0:0]           c_accum   = 1'b1;
    localparam logic [ACC_WIDTH-1:0] c_acc_max = '1;

    logic [0:0]           r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_sat;
    logic [LEN_WIDTH-1:0] r_count;

    logic [ACC_WIDTH-1:0] r_fifo_data [0:1];
    logic [1:0]           r_fifo_sat;
    logic                 r_rd_ptr;
    logic                 r_wr_ptr;
    logic [1:0]           r_fifo_cnt;
    logic                 r_overrun;

    logic                 w_start_ok;
    logic                 w_term;
    logic                 w_last;
    logic [LEN_WIDTH-1:0] w_count;
    logic [ACC_WIDTH-1:0] w_base;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_ovf;
    logic [ACC_WIDTH-1:0] w_next_acc;
    logic                 w_next_sat;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    // An accepted start restarts the sum from zero, so a product arriving in
    // the same cycle becomes the first term.
    always_comb begin
        w_start_ok = (r_state == c_idle) && bus.i_start && (bus.i_len != '0);
        w_base     = w_start_ok ? '0 : r_acc;
        w_count    = w_start_ok ? bus.i_len : r_count;
        w_term     = bus.i_valid && (w_start_ok || (r_state == c_accum));
        w_last     = w_term && (w_count == LEN_WIDTH'(1));
        w_sum      = {1'b0, w_base} + (ACC_WIDTH + 1)'(bus.i_product);
        w_ovf      = w_sum[ACC_WIDTH];
        w_next_acc = w_ovf ? c_acc_max : w_sum[ACC_WIDTH-1:0];
        w_next_sat = (w_start_ok ? 1'b0 : r_sat) | w_ovf;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_idle;
            r_acc   <= '0;
            r_sat   <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_term) begin
                r_acc   <= w_next_acc;
                r_sat   <= w_next_sat;
                r_count <= w_count - LEN_WIDTH'(1);
            end else if (w_start_ok) begin
                r_acc   <= '0;
                r_sat   <= 1'b0;
                r_count <= bus.i_len;
            end
            if (w_last) begin
                r_state <= c_idle;
            end else if (w_start_ok) begin
                r_state <= c_accum;
            end
        end
    end

    // A pop in the push cycle frees the head slot, so a full FIFO still accepts.
    always_comb begin
        w_empty = (r_fifo_cnt == 2'd0);
        w_full  = (r_fifo_cnt == 2'd2);
        w_pop   = !w_empty && bus.i_ready;
        w_push  = w_last && (!w_full || w_pop);
        w_drop  = w_last && w_full && !w_pop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
            end
            r_fifo_sat <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_next_acc;
                r_fifo_sat[r_wr_ptr]  <= w_next_sat;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.o_valid   = !w_empty;
    assign bus.o_result  = w_empty ? '0 : r_fifo_data[r_rd_ptr];
    assign bus.o_sat     = w_empty ? 1'b0 : r_fifo_sat[r_rd_ptr];
    assign bus.o_busy    = (r_state == c_accum);
    assign bus.o_overrun = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_accumulator
// Description : Scoreboard bench; two accumulator widths (24 and 20) share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;
    localparam longint unsigned MAX_A = (64'd1 << 24) - 64'd1;
    localparam longint unsigned MAX_B = (64'd1 << 20) - 64'd1;

    typedef struct {
        longint unsigned ra;
        bit              sa;
        longint unsigned rb;
        bit              sb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        t_start = 1'b0;
    logic [7:0]  t_len = 8'd0;
    logic        t_valid = 1'b0;
    logic [15:0] t_prod = 16'd0;
    logic        t_ready = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;
    int          rdy_mode = 1;
    bit          exp_ovf = 1'b0;
    exp_t        q[$];
    exp_t        pend;
    int unsigned p_arr [256];

    always #5 clk = ~clk;

    mac_accumulator_if #(.IN_DATA_WIDTH(16), .ACC_WIDTH(24), .LEN_WIDTH(8)) bus_a ();
    mac_accumulator_if #(.IN_DATA_WIDTH(16), .ACC_WIDTH(20), .LEN_WIDTH(8)) bus_b ();

    assign bus_a.i_start   = t_start;
    assign bus_a.i_len     = t_len;
    assign bus_a.i_valid   = t_valid;
    assign bus_a.i_product = t_prod;
    assign bus_a.i_ready   = t_ready;
    assign bus_b.i_start   = t_start;
    assign bus_b.i_len     = t_len;
    assign bus_b.i_valid   = t_valid;
    assign bus_b.i_product = t_prod;
    assign bus_b.i_ready   = t_ready;

    mac_accumulator #(.IN_DATA_WIDTH(16), .ACC_WIDTH(24), .LEN_WIDTH(8)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    mac_accumulator #(.IN_DATA_WIDTH(16), .ACC_WIDTH(20), .LEN_WIDTH(8)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result of a dot product: the true sum clamped to the result width.
    function automatic void set_pend(input longint unsigned s);
        pend.ra = (s > MAX_A) ? MAX_A : s;
        pend.sa = (s > MAX_A);
        pend.rb = (s > MAX_B) ? MAX_B : s;
        pend.sb = (s > MAX_B);
    endfunction

    // One clock of stimulus; a completing result is queued only if the FIFO
    // (as seen by the scoreboard after this cycle's pop) has room.
    task automatic drive(input bit s, input int unsigned len, input bit v,
                         input int unsigned p, input bit push);
        @(posedge clk);
        #1;
        t_start = s;
        t_len   = len[7:0];
        t_valid = v;
        t_prod  = p[15:0];
        t_ready = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
        @(negedge clk);
        #1;
        if (push) begin
            if (q.size() < 2) q.push_back(pend);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic run_dot(input int len, input bit first, input int max_gap);
        longint unsigned s;
        int idx;
        s = 0;
        for (int i = 0; i < len; i++) s += 64'(p_arr[i]);
        set_pend(s);
        if (first) begin
            drive(1'b1, len, 1'b1, p_arr[0], len == 1);
            idx = 1;
        end else begin
            drive(1'b1, len, 1'b0, $urandom, 1'b0);
            idx = 0;
        end
        while (idx < len) begin
            int g;
            g = int'($urandom_range(max_gap, 0));
            for (int k = 0; k < g; k++)
                drive(1'($urandom_range(1, 0)), $urandom_range(255, 0), 1'b0, $urandom, 1'b0);
            drive(1'b0, $urandom_range(255, 0), 1'b1, p_arr[idx], idx == len - 1);
            idx++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_a"},  64'(bus_a.o_valid),   64'(0));
        check({tag, "_result_a"}, 64'(bus_a.o_result),  64'(0));
        check({tag, "_sat_a"},    64'(bus_a.o_sat),     64'(0));
        check({tag, "_busy_a"},   64'(bus_a.o_busy),    64'(0));
        check({tag, "_ovr_a"},    64'(bus_a.o_overrun), 64'(0));
        check({tag, "_valid_b"},  64'(bus_b.o_valid),   64'(0));
        check({tag, "_busy_b"},   64'(bus_b.o_busy),    64'(0));
        check({tag, "_ovr_b"},    64'(bus_b.o_overrun), 64'(0));
    endtask

    // Monitor: compares the FIFO head against the scoreboard every cycle.
    always @(negedge clk) begin
        check("valid_a", 64'(bus_a.o_valid), 64'(q.size() != 0));
        check("valid_b", 64'(bus_b.o_valid), 64'(q.size() != 0));
        check("overrun_a", 64'(bus_a.o_overrun), 64'(exp_ovf));
        check("overrun_b", 64'(bus_b.o_overrun), 64'(exp_ovf));
        if (q.size() != 0) begin
            check("result_a", 64'(bus_a.o_result), q[0].ra);
            check("sat_a",    64'(bus_a.o_sat),    64'(q[0].sa));
            check("result_b", 64'(bus_b.o_result), q[0].rb);
            check("sat_b",    64'(bus_b.o_sat),    64'(q[0].sb));
            if (t_ready) void'(q.pop_front());
        end else begin
            check("empty_a", 64'({bus_a.o_sat, bus_a.o_result}), 64'(0));
            check("empty_b", 64'({bus_b.o_sat, bus_b.o_result}), 64'(0));
        end
    end

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // 10 + 20 + 30 with busy tracking
        rdy_mode = 1;
        set_pend(64'd60);
        drive(1'b1, 3, 1'b0, 0, 1'b0);
        drive(1'b0, 0, 1'b1, 10, 1'b0);
        check("busy_on", 64'(bus_a.o_busy), 64'(1));
        drive(1'b0, 0, 1'b1, 20, 1'b0);
        drive(1'b0, 0, 1'b1, 30, 1'b1);
        check("busy_last", 64'(bus_a.o_busy), 64'(1));
        idle(1);
        check("busy_off", 64'(bus_a.o_busy), 64'(0));
        idle(2);

        // stray pulses in IDLE, zero-length start, then 1..4 with gaps
        repeat (3) drive(1'b0, $urandom_range(255, 0), 1'b1, $urandom, 1'b0);
        drive(1'b1, 0, 1'b1, $urandom, 1'b0);
        check("len0_ignored", 64'(bus_a.o_busy), 64'(0));
        for (int i = 0; i < 4; i++) p_arr[i] = i + 1;
        run_dot(4, 1'b0, 3);
        idle(2);

        // large sums: fits at 24 bits, saturates at 20 bits
        for (int i = 0; i < 255; i++) p_arr[i] = 32'hFFFF;
        run_dot(255, 1'b1, 0);
        idle(1);
        run_dot(20, 1'b0, 1);
        p_arr[0] = 1; p_arr[1] = 1;
        run_dot(2, 1'b1, 0);
        idle(2);

        // full FIFO with a pop in the push cycle: no overrun
        rdy_mode = 0;
        p_arr[0] = 11; run_dot(1, 1'b1, 0);
        p_arr[0] = 12; run_dot(1, 1'b1, 0);
        rdy_mode = 1;
        p_arr[0] = 13; run_dot(1, 1'b1, 0);
        idle(4);

        // three results into a stalled consumer: third one dropped
        rdy_mode = 0;
        p_arr[0] = 5; run_dot(1, 1'b1, 0);
        p_arr[0] = 6; run_dot(1, 1'b1, 0);
        p_arr[0] = 7; run_dot(1, 1'b1, 0);
        idle(2);
        rdy_mode = 1;
        idle(4);

        // async reset mid-dot-product with a result queued
        rdy_mode = 0;
        p_arr[0] = 9; run_dot(1, 1'b1, 0);
        drive(1'b1, 4, 1'b0, 0, 1'b0);
        drive(1'b0, 0, 1'b1, 3, 1'b0);
        drive(1'b0, 0, 1'b1, 4, 1'b0);
        t_valid = 1'b0;
        t_start = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        rdy_mode = 1;
        p_arr[0] = 3; p_arr[1] = 4;
        run_dot(2, 1'b0, 0);
        idle(2);

        // randomized traffic with a random consumer
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            int len;
            bit big;
            big = ($urandom_range(7, 0) == 0);
            len = big ? int'($urandom_range(40, 16)) : int'($urandom_range(6, 1));
            for (int i = 0; i < len; i++)
                p_arr[i] = big ? $urandom_range(32'hFFFF, 32'hC000) : $urandom_range(32'hFFFF, 0);
            for (int k = int'($urandom_range(2, 0)); k > 0; k--)
                drive(1'b0, $urandom_range(255, 0), 1'($urandom_range(1, 0)), $urandom, 1'b0);
            run_dot(len, 1'($urandom_range(1, 0)), 2);
        end

        rdy_mode = 1;
        for (int k = 0; k < 20 && q.size() != 0; k++) idle(1);
        check("drain", 64'(q.size()), 64'(0));
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
